// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch and program-counter stage of the nRisc core.
// Each instruction walks through FETCH -> DECODE -> EXEC. The instruction
// register feeds the control unit. The registered control decisions,
// together with the ULA Zero flag, pick the next PC or stop the core.
module fetch_pc_unit #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                Clock,
    input  logic                Reset_n,
    output logic                IMemReq,
    output logic [PC_WIDTH-1:0] IMemAddr,
    input  logic                IMemAck,
    input  logic [7:0]          IMemData,
    output logic [7:0]          Instr,
    output logic [2:0]          OPcode,
    output logic                InstrValid,
    input  logic                Branch,
    input  logic                Jump,
    input  logic                EscPc,
    input  logic                Zero,
    output logic [PC_WIDTH-1:0] PC,
    output logic                Halted
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    // Opcode 3'b111 with zero operands is halt, so the control unit idles
    // with its register-file and memory write enables low.
    localparam logic [7:0] HALT_INSTR = 8'hE0;

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          instr_q, instr_d;
    logic                req_q, req_d;
    logic                valid_q, valid_d;
    logic                halted_q, halted_d;

    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] jump_off;
    logic [PC_WIDTH-1:0] branch_off;
    logic [PC_WIDTH-1:0] pc_next;

    // Next-PC selection. Jump beats a taken branch, and a taken branch beats
    // a plain increment. The if-conditions treat x/z on the control inputs
    // as not asserted. Every sum wraps modulo 2^PC_WIDTH.
    always_comb begin
        pc_inc     = pc_q + PC_WIDTH'(1);
        jump_off   = {{(PC_WIDTH-5){instr_q[4]}}, instr_q[4:0]};
        branch_off = {{(PC_WIDTH-3){instr_q[2]}}, instr_q[2:0]};
        if (Jump == 1'b1) begin
            pc_next = pc_inc + jump_off;
        end else if ((Branch == 1'b1) && (Zero == 1'b1)) begin
            pc_next = pc_inc + branch_off;
        end else begin
            pc_next = pc_inc;
        end
    end

    // Sequencer. A request stays up with a stable address until it is acked.
    // An ack only counts while the request is actually up in FETCH. A halt
    // freezes everything until the core is reset.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        req_d    = req_q;
        valid_d  = 1'b0;
        halted_d = halted_q;
        case (state_q)
            S_FETCH: begin
                if (req_q && (IMemAck == 1'b1)) begin
                    instr_d = IMemData;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (EscPc == 1'b1) begin
                    pc_d    = pc_next;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    req_d    = 1'b0;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end
            end
            S_HALT: begin
                req_d    = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_FETCH;
            end
        endcase
    end

    // State registers. The asynchronous reset drops an outstanding request
    // at once, so an ack that arrives late is never mistaken for a new fetch.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= HALT_INSTR;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign IMemReq    = req_q;
    assign IMemAddr   = pc_q;
    assign Instr      = instr_q;
    assign OPcode     = instr_q[7:5];
    assign InstrValid = valid_q;
    assign PC         = pc_q;
    assign Halted     = halted_q;

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch and program-counter stage of the nRisc core. Holds the PC, fetches one 8-bit instruction per step from instruction memory over a req/ack handshake, and presents the opcode to the control unit. One cycle later it consumes the control unit's registered Branch/Jump/EscPc outputs, plus the ULA Zero flag, to compute the next PC or to halt.

## Interface
- PC_WIDTH, 8, width of PC and instruction-memory address
- RESET_PC, 8'h00, PC value loaded on reset
- Clock  in  1  rising-edge system clock
- Reset_n  in  1  asynchronous, active-low reset
- IMemReq  out  1  instruction-memory read request
- IMemAddr  out  PC_WIDTH  read address (always equals PC)
- IMemAck  in  1  memory accepted request; IMemData valid this cycle
- IMemData  in  8  instruction word
- Instr  out  8  instruction register
- OPcode  out  3  Instr[7:5], to control unit
- InstrValid  out  1  high during DECODE (new instruction at OPcode)
- Branch  in  1  from control unit
- Jump  in  1  from control unit
- EscPc  in  1  from control unit; 0 = halt
- Zero  in  1  ULA equality flag
- PC  out  PC_WIDTH  current program counter
- Halted  out  1  core stopped

## Operation
- Reset is asynchronous and active-low. Reset values: PC=RESET_PC, state=FETCH, IMemReq=0, Instr=8'hE0 (halt opcode, so the control unit idles with EscReg/EscMem=0), InstrValid=0, Halted=0.
- States: FETCH, DECODE, EXEC, HALT. All outputs are registered except IMemAddr=PC and OPcode=Instr[7:5].
- FETCH:
  - IMemReq=1.
  - On a posedge with IMemAck=1: Instr<=IMemData, then go to DECODE. IMemReq drops in the next cycle.
  - IMemAck while IMemReq=0 or outside FETCH is ignored.
- DECODE: InstrValid=1 for exactly one cycle. The control unit registers its outputs at the end of this cycle. Always go to EXEC.
- EXEC: sample Branch, Jump, EscPc, Zero. Only logic 1 counts as asserted; x/z counts as 0.
  - EscPc=0: PC unchanged, go to HALT.
  - Else if Jump=1: PC <= PC+1+sext(Instr[4:0]).
  - Else if Branch=1 and Zero=1: PC <= PC+1+sext(Instr[2:0]).
  - Otherwise: PC <= PC+1.
  - Then go to FETCH.
  - Priority is EscPc=0 > Jump > taken Branch > increment.
- Arithmetic: offsets are sign-extended to PC_WIDTH. All PC sums wrap modulo 2^PC_WIDTH, with no flag.
- HALT: Halted=1, IMemReq=0, PC and Instr frozen. The only exit is Reset_n.

## Timing
- Minimum 3 cycles per instruction: FETCH with same-cycle ack, then DECODE, then EXEC. Each wait cycle in FETCH adds 1.
- A request is held, with a stable address, until ack. There is no abort.
- Halted rises in the cycle after the EXEC that saw EscPc=0.
- Reset mid-FETCH (IMemReq high) drops IMemReq immediately and asynchronously. A later stray ack is ignored until FETCH re-requests on the first cycle after Reset_n deasserts.
- PC changes only on the EXEC→FETCH edge.

## Test plan
- Reset: hold Reset_n=0 with Clock running → PC=00, Instr=E0, IMemReq=0, InstrValid=0, Halted=0. Release → IMemReq=1 with IMemAddr=00 on the next cycle.
- Sequential fetch: ack after 0 wait cycles, then after 3 wait cycles, with data 0x00 (add) and Branch=Jump=0, EscPc=1 → PC goes 00→01→02. Instructions take 3 and 6 cycles. InstrValid pulses once per instruction.
- beq at PC=05, Instr=0x66 (offset -2):
  - Branch=1, Zero=1 → PC=04.
  - Repeat with Zero=0 → PC=06.
- Jump wrap: PC=FE, Instr=0x85 (offset +5), Jump=1, Branch=1, Zero=1 → PC=04 (jump wins; 0xFF+5 wraps).
- Halt: Instr=0xE0, EscPc=0 → Halted=1 the next cycle, PC unchanged, IMemReq stays 0 for 20 cycles despite IMemAck pulses.
- Reset mid-wait: assert Reset_n=0 during FETCH with ack pending, then release → PC=RESET_PC. The first Instr latched is from address 00, not the aborted address.
